instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 86 ++++++++
 rtl/enc_fifo.sv | 56 +++++
 rtl/instr_encoder.sv | 132 +++++++++++++
 tb/tb_instr_encoder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared RV32IM encoding constants, request class codes and op-code decode helpers.
// Used by the encoder and by the matching decoder.
package instr_encoder_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    CLS_REG    = 3'd0,
    CLS_IMM    = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JAL    = 3'd5,
    CLS_JALR   = 3'd6,
    CLS_MUL    = 3'd7
  } cls_e;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLTU = 5'd8;
  localparam logic [4:0] ALU_SLT  = 5'd9;

  localparam logic [4:0] BR_BEQ  = 5'd0;
  localparam logic [4:0] BR_BNE  = 5'd1;
  localparam logic [4:0] BR_BLT  = 5'd2;
  localparam logic [4:0] BR_BGE  = 5'd3;
  localparam logic [4:0] BR_BLTU = 5'd4;
  localparam logic [4:0] BR_BGEU = 5'd5;

  localparam logic [4:0] MUL_FIRST = 5'h0A;
  localparam logic [4:0] MUL_LAST  = 5'h11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef struct packed {
    logic [2:0] f3;
    logic       alt;
    logic       ok;
  } alu_dec_t;

  function automatic alu_dec_t alu_decode(input logic [4:0] op);
    alu_dec_t d;
    d = '{f3: 3'b000, alt: 1'b0, ok: 1'b1};
    case (op)
      ALU_ADD:  d.f3 = 3'b000;
      ALU_SUB:  d.alt = 1'b1;
      ALU_AND:  d.f3 = 3'b111;
      ALU_OR:   d.f3 = 3'b110;
      ALU_XOR:  d.f3 = 3'b100;
      ALU_SLL:  d.f3 = 3'b001;
      ALU_SRL:  d.f3 = 3'b101;
      ALU_SRA:  begin d.f3 = 3'b101; d.alt = 1'b1; end
      ALU_SLTU: d.f3 = 3'b011;
      ALU_SLT:  d.f3 = 3'b010;
      default:  d.ok = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [2:0] br_funct3(input logic [4:0] op);
    case (op)
      BR_BEQ:  return 3'b000;
      BR_BNE:  return 3'b001;
      BR_BLT:  return 3'b100;
      BR_BGE:  return 3'b101;
      BR_BLTU: return 3'b110;
      BR_BGEU: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Output word FIFO for the instruction encoder; zero is presented while empty.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_encoder.sv
// Turns structured instruction requests into RV32IM words, queues them and
// hands them to the instruction-memory writer with sequential byte addresses.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          IMEM_WORDS = 256,
  parameter int          DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_class,
  input  logic [4:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  input  logic        err_clr,
  output logic [15:0] word_count
);

  localparam int AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

  cls_e        cls;
  alu_dec_t    alu;
  logic        is_shift;
  logic [31:0] instr;
  logic        legal;
  logic        accept;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [AW-1:0] widx;
  logic        unused_imm_hi;

  assign cls           = cls_e'(in_class);
  assign unused_imm_hi = ^in_imm[31:21];

  always_comb begin
    instr    = '0;
    legal    = 1'b0;
    alu      = alu_decode(in_op);
    is_shift = (in_op == ALU_SLL) || (in_op == ALU_SRL) || (in_op == ALU_SRA);
    case (cls)
      CLS_REG: begin
        legal = alu.ok;
        instr = {alu.alt ? F7_ALT : F7_BASE, in_rs2, in_rs1, alu.f3, in_rd, OPC_OP};
      end
      CLS_IMM: begin
        legal = alu.ok && (in_op != ALU_SUB);
        if (is_shift)
          instr = {alu.alt ? F7_ALT : F7_BASE, in_imm[4:0], in_rs1, alu.f3, in_rd, OPC_OP_IMM};
        else
          instr = {in_imm[11:0], in_rs1, alu.f3, in_rd, OPC_OP_IMM};
      end
      CLS_LOAD: begin
        legal = (in_op == 5'd0) || (in_op == 5'd1) || (in_op == 5'd2) ||
                (in_op == 5'd4) || (in_op == 5'd5);
        instr = {in_imm[11:0], in_rs1, in_op[2:0], in_rd, OPC_LOAD};
      end
      CLS_STORE: begin
        legal = (in_op <= 5'd2);
        instr = {in_imm[11:5], in_rs2, in_rs1, in_op[2:0], in_imm[4:0], OPC_STORE};
      end
      CLS_BRANCH: begin
        legal = (in_op <= BR_BGEU);
        instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, br_funct3(in_op),
                 in_imm[4:1], in_imm[11], OPC_BRANCH};
      end
      CLS_JAL: begin
        legal = 1'b1;
        instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
      end
      CLS_JALR: begin
        legal = 1'b1;
        instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
      end
      CLS_MUL: begin
        legal = (in_op >= MUL_FIRST) && (in_op <= MUL_LAST);
        instr = {F7_MUL, in_rs2, in_rs1, 3'(in_op - MUL_FIRST), in_rd, OPC_OP};
      end
    endcase
  end

  // Illegal requests are consumed but never reach the queue.
  assign accept    = in_valid & in_ready;
  assign push      = accept & legal;
  assign pop       = out_valid & out_ready;
  assign in_ready  = ~full;
  assign out_valid = ~empty;

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (instr),
    .pop   (pop),
    .dout  (out_instr),
    .full  (full),
    .empty (empty)
  );

  assign out_addr = BASE_ADDR + (32'(widx) << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      widx       <= '0;
      word_count <= '0;
    end else if (pop) begin
      widx <= (widx == AW'(IMEM_WORDS - 1)) ? '0 : widx + 1'b1;
      if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    err <= 1'b0;
    else if (err_clr)           err <= 1'b0;
    else if (accept && !legal)  err <= 1'b1;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus random requests
// compared against a field-assembly reference model and a queue of expected words.
module tb_instr_encoder;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] BASE   = 32'h0;
  localparam logic [31:0] BASE_W = 32'h100;
  localparam int ALU_F3 [10] = '{0, 0, 7, 6, 4, 1, 5, 5, 3, 2};
  localparam int BR_F3  [6]  = '{0, 1, 4, 5, 6, 7};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_class = '0;
  logic [4:0]  in_op = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_ready = 1'b0;
  logic        err_clr = 1'b0;

  logic        in_ready, out_valid, err;
  logic [31:0] out_instr, out_addr;
  logic [15:0] word_count;
  logic        in_ready_w, out_valid_w, err_w;
  logic [31:0] out_instr_w, out_addr_w;
  logic [15:0] word_count_w;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  int          idx = 0, idx_w = 0, cnt = 0;
  logic        exp_err = 1'b0;
  bit          use_known = 0;
  logic [31:0] known_word = '0;
  logic [31:0] popped_addr_w = '0;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(BASE), .IMEM_WORDS(256), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err), .err_clr(err_clr),
    .word_count(word_count));

  instr_encoder #(.BASE_ADDR(BASE_W), .IMEM_WORDS(4), .DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_class(in_class), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_instr(out_instr_w), .out_addr(out_addr_w), .err(err_w), .err_clr(err_clr),
    .word_count(word_count_w));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int hi7, input int f24, input int f19,
                                       input int f3, input int f11, input int opc);
    return (32'(hi7) << 25) | (32'(f24) << 20) | (32'(f19) << 15) |
           (32'(f3) << 12) | (32'(f11) << 7) | 32'(opc);
  endfunction

  // Reference encoder: assembles each format straight from the ISA field layout.
  function automatic logic [31:0] model(input int cls, input int op, input int rd,
                                        input int rs1, input int rs2,
                                        input logic [31:0] imm, output bit ok);
    int hi7, lo5, j;
    logic [31:0] w;
    ok = 0;
    w  = '0;
    case (cls)
      0: if (op <= 9) begin
        ok = 1;
        w  = pack((op == 1 || op == 7) ? 32 : 0, rs2, rs1, ALU_F3[op], rd, 'h33);
      end
      1: if (op <= 9 && op != 1) begin
        ok = 1;
        if (op >= 5 && op <= 7)
          w = pack((op == 7) ? 32 : 0, int'(imm % 32), rs1, ALU_F3[op], rd, 'h13);
        else
          w = pack(int'((imm >> 5) & 127), int'(imm & 31), rs1, ALU_F3[op], rd, 'h13);
      end
      2: if (op == 0 || op == 1 || op == 2 || op == 4 || op == 5) begin
        ok = 1;
        w  = pack(int'((imm >> 5) & 127), int'(imm & 31), rs1, op, rd, 'h03);
      end
      3: if (op <= 2) begin
        ok = 1;
        w  = pack(int'((imm >> 5) & 127), rs2, rs1, op, int'(imm & 31), 'h23);
      end
      4: if (op <= 5) begin
        ok  = 1;
        hi7 = int'((imm >> 12) & 1) * 64 + int'((imm >> 5) & 63);
        lo5 = int'((imm >> 1) & 15) * 2 + int'((imm >> 11) & 1);
        w   = pack(hi7, rs2, rs1, BR_F3[op], lo5, 'h63);
      end
      5: begin
        ok = 1;
        j  = (int'((imm >> 20) & 1) << 19) | (int'((imm >> 1) & 1023) << 9) |
             (int'((imm >> 11) & 1) << 8) | int'((imm >> 12) & 255);
        w  = (32'(j) << 12) | (32'(rd) << 7) | 32'h6F;
      end
      6: begin
        ok = 1;
        w  = pack(int'((imm >> 5) & 127), int'(imm & 31), rs1, 0, rd, 'h67);
      end
      default: if (op >= 10 && op <= 17) begin
        ok = 1;
        w  = pack(1, rs2, rs1, op - 10, rd, 'h33);
      end
    endcase
    return w;
  endfunction

  // One clock: check outputs against the model, advance both across the edge.
  task automatic tick();
    int          sz;
    bit          ok, illegal;
    logic [31:0] w;
    sz = q.size();
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(sz < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(sz != 0));
      if (sz != 0) begin
        chk("out_instr", out_instr, q[0]);
        chk("out_addr", out_addr, BASE + 32'(idx * 4));
        chk("out_addr_w", out_addr_w, BASE_W + 32'(idx_w * 4));
        if (out_ready) popped_addr_w = out_addr_w;
      end
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      idx = 0; idx_w = 0; cnt = 0; exp_err = 1'b0;
    end else begin
      illegal = 0;
      if (sz != 0 && out_ready) begin
        void'(q.pop_front());
        idx   = (idx + 1) % 256;
        idx_w = (idx_w + 1) % 4;
        if (cnt < 65535) cnt++;
      end
      if (in_valid && sz < DEPTH) begin
        w = model(int'(in_class), int'(in_op), int'(in_rd), int'(in_rs1),
                  int'(in_rs2), in_imm, ok);
        if (use_known) w = known_word;
        if (ok) q.push_back(w);
        else illegal = 1;
      end
      if (err_clr) exp_err = 1'b0;
      else if (illegal) exp_err = 1'b1;
    end
    @(negedge clk);
    chk("err", 32'(err), 32'(exp_err));
    chk("word_count", 32'(word_count), 32'(cnt));
    chk("word_count_w", 32'(word_count_w), 32'(cnt));
  endtask

  task automatic send(input int cls, input int op, input int rd, input int rs1,
                      input int rs2, input logic [31:0] imm);
    bit acc;
    in_valid = 1'b1;
    in_class = 3'(cls); in_op = 5'(op); in_rd = 5'(rd);
    in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
    acc = 0;
    for (int n = 0; n < 40 && !acc; n++) begin
      acc = in_ready;
      tick();
    end
    chk("accept_timeout", 32'(acc), 32'd1);
    in_valid  = 1'b0;
    use_known = 0;
  endtask

  task automatic send_known(input int cls, input int op, input int rd, input int rs1,
                            input int rs2, input logic [31:0] imm, input logic [31:0] word);
    use_known  = 1;
    known_word = word;
    send(cls, op, rd, rs1, rs2, imm);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (DEPTH + 2) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Basic and control/memory encodings with a free-running consumer.
    out_ready = 1'b1;
    send_known(1, 0, 1, 0, 0, 32'd5, 32'h00500093);
    send_known(0, 0, 3, 1, 2, 32'd0, 32'h002081B3);
    send_known(0, 1, 3, 1, 2, 32'd0, 32'h402081B3);
    send_known(7, 10, 3, 1, 2, 32'd0, 32'h022081B3);
    send_known(4, 0, 0, 1, 2, 32'd8, 32'h00208463);
    send_known(5, 0, 1, 0, 0, 32'd16, 32'h010000EF);
    send_known(2, 2, 5, 2, 0, 32'd4, 32'h00412283);
    drain();

    // Random requests with random consumer stalls and occasional err_clr.
    for (int i = 0; i < 120; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 7) == 0);
      send(int'($urandom_range(0, 7)), int'($urandom_range(0, 17)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), $urandom);
    end
    err_clr = 1'b0;
    drain();

    // Backpressure: four fill the queue, the fifth waits for the first pop.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 0, i + 1, 1, 2, 32'd0);
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    chk("bp_head_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    send(0, 0, 5, 1, 2, 32'd0);
    drain();
    chk("bp_word_count", 32'(word_count), 32'd5);
    chk("bp_next_addr", out_addr, 32'h14);

    // Address wrap on the four-word window instance.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(3, 2, 0, i, i + 1, 32'(i * 4));
    drain();
    chk("wrap_fifth_addr", popped_addr_w, BASE_W);
    chk("wrap_word_count", 32'(word_count_w), 32'd5);

    // Illegal requests set err without output; err_clr beats a same-cycle error.
    do_reset();
    out_ready = 1'b1;
    send(1, 1, 1, 0, 0, 32'd5);
    send(2, 3, 5, 2, 0, 32'd4);
    drain();
    chk("illegal_no_output", 32'(word_count), 32'd0);
    chk("illegal_err_set", 32'(err), 32'd1);
    err_clr = 1'b1;
    send(1, 1, 1, 0, 0, 32'd5);
    err_clr = 1'b0;
    chk("illegal_err_clr_wins", 32'(err), 32'd0);

    // Reset with three words queued discards them.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(6, 0, i, i, 0, 32'(i));
    chk("rst_mid_queued", 32'(out_valid), 32'd1);
    do_reset();
    out_ready = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
